// File: rtl/data_array_pkg.sv
// rtl/data_array_pkg.sv - shared types and helpers for the n-way cache data store
package data_array_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_ACTIVE = 2'd1,
    FILL_DONE   = 2'd2
  } fill_state_e;

  // Number of fill beats needed to cover one line.
  function automatic int beat_count(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  // True when line byte byte_idx lies inside the beat selected by beat_cnt.
  function automatic logic beat_covers(input int byte_idx, input int beat_cnt, input int beat_bytes);
    return (byte_idx / beat_bytes) == beat_cnt;
  endfunction

endpackage

// File: rtl/data_way_bank.sv
// rtl/data_way_bank.sv - one way of line storage with byte-enable writes and async read
module data_way_bank
  import data_array_pkg::*;
#(
  parameter int S_INDEX = 3,
  parameter int S_MASK  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_MASK-1:0]     a_mask,
  input  logic [S_INDEX-1:0]    a_index,
  input  logic [8*S_MASK-1:0]   a_data,
  input  logic [S_MASK-1:0]     b_mask,
  input  logic [S_INDEX-1:0]    b_index,
  input  logic [8*S_MASK-1:0]   b_data,
  input  logic [S_INDEX-1:0]    rd_index,
  output logic [8*S_MASK-1:0]   rd_data
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [8*S_MASK-1:0] mem [NUM_SETS];

  // Byte writes from two ports; port a (fill) takes the byte when both hit the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) mem[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int b = 0; b < S_MASK; b++) begin
          if (a_mask[b] && (a_index == S_INDEX'(s)))
            mem[s][8*b +: 8] <= a_data[8*b +: 8];
          else if (b_mask[b] && (b_index == S_INDEX'(s)))
            mem[s][8*b +: 8] <= b_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/data_array_nway.sv
// rtl/data_array_nway.sv - n-way cache data store with CPU byte writes and beat-wise line fill
module data_array_nway
  import data_array_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int BEAT_W   = 64,
  localparam int S_MASK  = 2 ** S_OFFSET,
  localparam int LINE_W  = 8 * S_MASK,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [WAY_W-1:0]    rd_way,
  input  logic [S_INDEX-1:0]  rd_index,
  output logic                rd_valid,
  output logic [LINE_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic [S_INDEX-1:0]  wr_index,
  input  logic [S_MASK-1:0]   wr_mask,
  input  logic [LINE_W-1:0]   wr_data,
  input  logic                fill_start,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [S_INDEX-1:0]  fill_index,
  input  logic                fill_beat_valid,
  input  logic [BEAT_W-1:0]   fill_beat_data,
  output logic                fill_busy,
  output logic                fill_done
);

  localparam int BEATS   = beat_count(LINE_W, BEAT_W);
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_e          state, state_nxt;
  logic [BEAT_CW-1:0]   beat_cnt;
  logic [WAY_W-1:0]     fill_way_q;
  logic [S_INDEX-1:0]   fill_index_q;
  logic                 fill_fire;
  logic                 fill_last;
  logic [S_MASK-1:0]    fill_sel;
  logic [LINE_W-1:0]    fill_line;
  logic [LINE_W-1:0]    bank_rd [NUM_WAYS];
  logic [LINE_W-1:0]    rd_next;

  assign fill_fire = (state == FILL_ACTIVE) && fill_beat_valid;
  assign fill_last = (beat_cnt == BEAT_CW'(BEATS - 1));
  // Replicating the beat across the line puts each beat byte at its line position.
  assign fill_line = {BEATS{fill_beat_data}};
  assign fill_busy = (state == FILL_ACTIVE);
  assign fill_done = (state == FILL_DONE);

  // Bytes of the line covered by the beat being written this cycle.
  always_comb begin
    fill_sel = '0;
    for (int i = 0; i < S_MASK; i++)
      fill_sel[i] = fill_fire && beat_covers(i, int'(beat_cnt), BEAT_W / 8);
  end

  // Fill state register, beat counter and latched fill target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL_IDLE;
      beat_cnt     <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
    end else begin
      state <= state_nxt;
      if (state != FILL_ACTIVE && fill_start) begin
        fill_way_q   <= fill_way;
        fill_index_q <= fill_index;
        beat_cnt     <= '0;
      end else if (fill_fire) begin
        beat_cnt <= fill_last ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // Fill next-state: start from IDLE/DONE, finish on the last beat, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL_IDLE:   if (fill_start) state_nxt = FILL_ACTIVE;
      FILL_ACTIVE: if (fill_fire && fill_last) state_nxt = FILL_DONE;
      FILL_DONE:   state_nxt = fill_start ? FILL_ACTIVE : FILL_IDLE;
      default:     state_nxt = FILL_IDLE;
    endcase
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [S_MASK-1:0] fill_mask_w;
    logic [S_MASK-1:0] cpu_mask_w;

    assign fill_mask_w = (fill_way_q == WAY_W'(w)) ? fill_sel : '0;
    assign cpu_mask_w  = (wr_en && wr_way == WAY_W'(w)) ? wr_mask : '0;

    data_way_bank #(
      .S_INDEX (S_INDEX),
      .S_MASK  (S_MASK)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .a_mask   (fill_mask_w),
      .a_index  (fill_index_q),
      .a_data   (fill_line),
      .b_mask   (cpu_mask_w),
      .b_index  (wr_index),
      .b_data   (wr_data),
      .rd_index (rd_index),
      .rd_data  (bank_rd[w])
    );
  end

  // Read mux with per-byte bypass of same-edge writes, fill bytes over CPU bytes.
  always_comb begin
    logic fill_same;
    logic cpu_same;
    rd_next   = bank_rd[rd_way];
    fill_same = (fill_way_q == rd_way) && (fill_index_q == rd_index);
    cpu_same  = wr_en && (wr_way == rd_way) && (wr_index == rd_index);
    for (int i = 0; i < S_MASK; i++) begin
      if (fill_same && fill_sel[i])
        rd_next[8*i +: 8] = fill_line[8*i +: 8];
      else if (cpu_same && wr_mask[i])
        rd_next[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Registered read port; data holds when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_data_array_nway.sv
// tb/tb_data_array_nway.sv - directed table-driven bench for data_array_nway
module tb_data_array_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic [1:0]   rd_way;
  logic [2:0]   rd_index;
  logic         rd_valid;
  logic [255:0] rd_data;
  logic         wr_en;
  logic [1:0]   wr_way;
  logic [2:0]   wr_index;
  logic [31:0]  wr_mask;
  logic [255:0] wr_data;
  logic         fill_start;
  logic [1:0]   fill_way;
  logic [2:0]   fill_index;
  logic         fill_beat_valid;
  logic [63:0]  fill_beat_data;
  logic         fill_busy;
  logic         fill_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  data_array_nway dut (
    .clk             (clk),
    .rst             (rst),
    .rd_en           (rd_en),
    .rd_way          (rd_way),
    .rd_index        (rd_index),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .wr_en           (wr_en),
    .wr_way          (wr_way),
    .wr_index        (wr_index),
    .wr_mask         (wr_mask),
    .wr_data         (wr_data),
    .fill_start      (fill_start),
    .fill_way        (fill_way),
    .fill_index      (fill_index),
    .fill_beat_valid (fill_beat_valid),
    .fill_beat_data  (fill_beat_data),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done)
  );

  typedef struct {
    string        name;
    logic         rd_en;
    logic [1:0]   rd_way;
    logic [2:0]   rd_index;
    logic         wr_en;
    logic [1:0]   wr_way;
    logic [2:0]   wr_index;
    logic [31:0]  wr_mask;
    logic [255:0] wr_data;
    logic         exp_valid;
    logic [255:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string n, logic re, logic [1:0] rw, logic [2:0] ri,
                              logic we, logic [1:0] ww, logic [2:0] wi, logic [31:0] wm,
                              logic [255:0] wd, logic ev, logic [255:0] ed);
    vec_t v;
    v.name = n; v.rd_en = re; v.rd_way = rw; v.rd_index = ri;
    v.wr_en = we; v.wr_way = ww; v.wr_index = wi; v.wr_mask = wm; v.wr_data = wd;
    v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 0; rd_way = 0; rd_index = 0;
    wr_en = 0; wr_way = 0; wr_index = 0; wr_mask = 0; wr_data = '0;
    fill_start = 0; fill_way = 0; fill_index = 0;
    fill_beat_valid = 0; fill_beat_data = '0;
  endtask

  // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(string n, logic [1:0] w, logic [2:0] s, logic [255:0] exp);
    @(negedge clk);
    idle_inputs();
    rd_en = 1; rd_way = w; rd_index = s;
    tick();
    chk({n, "_valid"}, 256'(rd_valid), 256'(1));
    chk({n, "_data"}, rd_data, exp);
  endtask

  logic [255:0] aa4, w1s3a, w1s3b, fill_exp, p5_exp, ff_exp;
  logic [63:0]  beats4 [4];
  logic         bv4 [5];
  int           busy_cycles, done_pulses, bi;

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    chk("rst_valid", 256'(rd_valid), 256'(0));
    chk("rst_data", rd_data, '0);
    chk("rst_busy", 256'(fill_busy), 256'(0));
    chk("rst_done", 256'(fill_done), 256'(0));
    #10 rst = 0;

    aa4   = {224'h0, {4{8'hAA}}};
    w1s3a = {{16{8'h55}}, 128'h0};
    w1s3b = {{16{8'h55}}, {16{8'h77}}};

    vecs[0]  = mk("rd_reset",  1, 0, 0, 0, 0, 0, 32'h0, '0, 1, '0);
    vecs[1]  = mk("wr_w2s5",   0, 0, 0, 1, 2, 5, 32'h0000_000F, {32{8'hAA}}, 0, '0);
    vecs[2]  = mk("rd_w2s5",   1, 2, 5, 0, 0, 0, 32'h0, '0, 1, aa4);
    vecs[3]  = mk("rdwr_w1s3", 1, 1, 3, 1, 1, 3, 32'hFFFF_0000, {32{8'h55}}, 1, w1s3a);
    vecs[4]  = mk("hold",      0, 1, 3, 1, 1, 3, 32'h0000_FFFF, {32{8'h77}}, 0, w1s3a);
    vecs[5]  = mk("rd_w1s3",   1, 1, 3, 0, 0, 0, 32'h0, '0, 1, w1s3b);
    vecs[6]  = mk("mask0",     1, 2, 5, 1, 2, 5, 32'h0, {32{8'hFF}}, 1, aa4);
    vecs[7]  = mk("diff_set",  1, 2, 5, 1, 2, 4, 32'hFFFF_FFFF, {32{8'h11}}, 1, aa4);
    vecs[8]  = mk("diff_way",  1, 2, 5, 1, 3, 5, 32'hFFFF_FFFF, {32{8'h22}}, 1, aa4);
    vecs[9]  = mk("overlap",   1, 2, 5, 1, 2, 5, 32'h0000_00F0, {32{8'h99}}, 1,
                  {192'h0, {4{8'h99}}, {4{8'hAA}}});
    vecs[10] = mk("rd_w2s4",   1, 2, 4, 0, 0, 0, 32'h0, '0, 1, {32{8'h11}});

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_en = vecs[i].rd_en; rd_way = vecs[i].rd_way; rd_index = vecs[i].rd_index;
      wr_en = vecs[i].wr_en; wr_way = vecs[i].wr_way; wr_index = vecs[i].wr_index;
      wr_mask = vecs[i].wr_mask; wr_data = vecs[i].wr_data;
      tick();
      chk({vecs[i].name, "_valid"}, 256'(rd_valid), 256'(vecs[i].exp_valid));
      chk({vecs[i].name, "_data"}, rd_data, vecs[i].exp_data);
    end

    // Four-beat fill of way3/set7 with one idle gap; beat_valid on the start cycle is ignored.
    beats4[0] = {8{8'h11}}; beats4[1] = {8{8'h22}};
    beats4[2] = {8{8'h33}}; beats4[3] = {8{8'h44}};
    bv4[0] = 1; bv4[1] = 1; bv4[2] = 0; bv4[3] = 1; bv4[4] = 1;
    fill_exp = {beats4[3], beats4[2], beats4[1], beats4[0]};
    busy_cycles = 0; done_pulses = 0; bi = 0;
    @(negedge clk);
    idle_inputs();
    fill_start = 1; fill_way = 3; fill_index = 7;
    fill_beat_valid = 1; fill_beat_data = {8{8'hEE}};
    tick();
    if (fill_busy) busy_cycles++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      fill_beat_valid = bv4[c];
      fill_beat_data  = bv4[c] ? beats4[bi] : {8{8'hDD}};
      if (bv4[c]) bi++;
      tick();
      if (fill_busy) busy_cycles++;
      if (fill_done) done_pulses++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      tick();
      if (fill_busy) busy_cycles++;
      if (fill_done) done_pulses++;
    end
    chk("fill_busy_cycles", 256'(busy_cycles), 256'(5));
    chk("fill_done_pulses", 256'(done_pulses), 256'(1));
    do_read("fill_rd", 3, 7, fill_exp);

    // Beat 0 and a full-mask CPU write to the same line in one cycle; fill bytes win.
    @(negedge clk);
    idle_inputs();
    fill_start = 1; fill_way = 0; fill_index = 1;
    tick();
    @(negedge clk);
    idle_inputs();
    fill_beat_valid = 1; fill_beat_data = 64'h0123_4567_89AB_CDEF;
    wr_en = 1; wr_way = 0; wr_index = 1; wr_mask = 32'hFFFF_FFFF; wr_data = {32{8'hCC}};
    rd_en = 1; rd_way = 0; rd_index = 1;
    tick();
    p5_exp = {{24{8'hCC}}, 64'h0123_4567_89AB_CDEF};
    chk("conflict_bypass", rd_data, p5_exp);
    do_read("conflict_stored", 0, 1, p5_exp);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      fill_beat_valid = 1; fill_beat_data = {8{8'hFF}};
      tick();
    end
    chk("conflict_fill_done", 256'(fill_done), 256'(1));
    ff_exp = {{24{8'hFF}}, 64'h0123_4567_89AB_CDEF};
    do_read("conflict_final", 0, 1, ff_exp);

    // Reset in the middle of a fill of way2/set2 after two beats.
    @(negedge clk);
    idle_inputs();
    fill_start = 1; fill_way = 2; fill_index = 2;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      fill_beat_valid = 1; fill_beat_data = c == 0 ? {8{8'hA1}} : {8{8'hB2}};
      tick();
    end
    do_read("partial_fill", 2, 2, {128'h0, {8{8'hB2}}, {8{8'hA1}}});
    @(negedge clk);
    idle_inputs();
    fill_beat_valid = 1; fill_beat_data = {8{8'hE7}};
    rst = 1;
    #1;
    chk("midrst_valid", 256'(rd_valid), 256'(0));
    chk("midrst_data", rd_data, '0);
    chk("midrst_busy", 256'(fill_busy), 256'(0));
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      fill_beat_valid = 1; fill_beat_data = {8{8'hE7}};
      tick();
      chk("postrst_busy", 256'(fill_busy), 256'(0));
      chk("postrst_done", 256'(fill_done), 256'(0));
    end
    do_read("postrst_w2s2", 2, 2, '0);
    do_read("postrst_w2s5", 2, 5, '0);
    do_read("postrst_w3s7", 3, 7, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
